// File: rtl/adc_sram_pkg.sv
// Shared types for the ADC-to-SRAM arbiter: FSM states, grant encoding
// and the active-low SRAM strobe bundle.
package adc_sram_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WRITE    = 2'd1,
      READ     = 2'd2,
      READ_CAP = 2'd3
   } state_e;

   typedef enum logic {
      GNT_ADC  = 1'b0,
      GNT_HOST = 1'b1
   } gnt_e;

   typedef struct packed {
      logic cs_n;
      logic we_n;
      logic oe_n;
   } strobe_t;

   localparam strobe_t STB_IDLE  = '{cs_n: 1'b1, we_n: 1'b1, oe_n: 1'b1};
   localparam strobe_t STB_WRITE = '{cs_n: 1'b0, we_n: 1'b0, oe_n: 1'b1};
   localparam strobe_t STB_READ  = '{cs_n: 1'b0, we_n: 1'b1, oe_n: 1'b0};

endpackage

// File: rtl/adc_sram_rr_arb.sv
// Two-requester round-robin arbiter: on a tie, grants whichever side was not
// granted last. gnt is one-hot, bit 0 = ADC, bit 1 = host.
module adc_sram_rr_arb
   import adc_sram_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic       req_adc,
   input  logic       req_host,
   input  logic       advance,
   output logic [1:0] gnt
);

   gnt_e last_q;

   // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      gnt = 2'b00;
      if (req_adc && (!req_host || last_q == GNT_HOST))
         gnt[0] = 1'b1;
      else if (req_host)
         gnt[1] = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         last_q <= GNT_HOST;
      else if (advance && gnt[0])
         last_q <= GNT_ADC;
      else if (advance && gnt[1])
         last_q <= GNT_HOST;
   end

endmodule

// File: rtl/adc_sram_arbiter.sv
// Shares one asynchronous SRAM between an ADC sample stream (one-entry
// holding register, circular write pointer) and a host read port.
module adc_sram_arbiter
   import adc_sram_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  adc_valid,
   input  logic [DATA_WIDTH-1:0] adc_data,
   output logic                  adc_ready,
   input  logic                  host_req,
   input  logic [ADDR_WIDTH-1:0] host_addr,
   output logic                  host_ack,
   output logic [DATA_WIDTH-1:0] host_rdata,
   output logic [ADDR_WIDTH-1:0] sram_addr,
   output logic [DATA_WIDTH-1:0] sram_dout,
   input  logic [DATA_WIDTH-1:0] sram_din,
   output logic                  sram_cs_n,
   output logic                  sram_we_n,
   output logic                  sram_oe_n,
   input  logic                  ovf_clr,
   output logic [ADDR_WIDTH-1:0] wr_ptr,
   output logic                  wrapped,
   output logic                  overflow
);

   state_e                state, next_state;
   strobe_t               stb_d;
   logic                  hold_valid;
   logic [DATA_WIDTH-1:0] hold_data;
   logic                  adc_accept, adc_drop, host_req_eff;
   logic [1:0]            gnt;

   // The holding register frees up during WRITE, so a new sample can land
   // in the same cycle the old one goes out.
   assign adc_ready    = !hold_valid || (state == WRITE);
   assign adc_accept   = adc_valid && adc_ready;
   assign adc_drop     = adc_valid && !adc_ready;
   assign host_req_eff = host_req && !host_ack;

   adc_sram_rr_arb u_arb (
      .clk      (clk),
      .reset_n  (reset_n),
      .req_adc  (hold_valid),
      .req_host (host_req_eff),
      .advance  (state == IDLE),
      .gnt      (gnt)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= next_state;
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE: begin
            if (gnt[0])      next_state = WRITE;
            else if (gnt[1]) next_state = READ;
         end
         WRITE:    next_state = IDLE;
         READ:     next_state = READ_CAP;
         READ_CAP: next_state = IDLE;
         default:  next_state = IDLE;
      endcase
   end

   // Strobes are decoded from next_state and registered, so the pins line
   // up with the state they belong to without combinational glitches.
   always_comb begin
      stb_d = STB_IDLE;
      unique case (next_state)
         WRITE:          stb_d = STB_WRITE;
         READ, READ_CAP: stb_d = STB_READ;
         default:        stb_d = STB_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         {sram_cs_n, sram_we_n, sram_oe_n} <= STB_IDLE;
         sram_addr  <= '0;
         sram_dout  <= '0;
         host_ack   <= 1'b0;
         host_rdata <= '0;
      end else begin
         {sram_cs_n, sram_we_n, sram_oe_n} <= stb_d;
         if (next_state == WRITE) begin
            sram_addr <= wr_ptr;
            sram_dout <= hold_data;
         end else if (next_state == READ || next_state == READ_CAP) begin
            sram_addr <= host_addr;
         end
         host_ack <= (state == READ_CAP);
         if (state == READ_CAP)
            host_rdata <= sram_din;
      end
   end

   // NOTE: hold_data is a single register, not a memory array, so it is cheap to reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hold_valid <= 1'b0;
         hold_data  <= '0;
         wr_ptr     <= '0;
         wrapped    <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         if (adc_accept) begin
            hold_valid <= 1'b1;
            hold_data  <= adc_data;
         end else if (state == WRITE) begin
            hold_valid <= 1'b0;
         end
         if (state == WRITE) begin
            wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            if (wr_ptr == '1)
               wrapped <= 1'b1;
         end
         // A drop in the same cycle as a clear wins: the loss must stay visible.
         if (adc_drop)
            overflow <= 1'b1;
         else if (ovf_clr)
            overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_adc_sram_arbiter.sv
// Directed testbench for adc_sram_arbiter with a behavioural async SRAM.
module tb_adc_sram_arbiter;

   localparam int DW = 8;
   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          adc_valid = 1'b0;
   logic [DW-1:0] adc_data = '0;
   logic          adc_ready;
   logic          host_req = 1'b0;
   logic [AW-1:0] host_addr = '0;
   logic          host_ack;
   logic [DW-1:0] host_rdata;
   logic [AW-1:0] sram_addr;
   logic [DW-1:0] sram_dout;
   logic [DW-1:0] sram_din;
   logic          sram_cs_n, sram_we_n, sram_oe_n;
   logic          ovf_clr = 1'b0;
   logic [AW-1:0] wr_ptr;
   logic          wrapped;
   logic          overflow;

   int n_cmp = 0;
   int n_bad = 0;

   adc_sram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .adc_valid  (adc_valid),
      .adc_data   (adc_data),
      .adc_ready  (adc_ready),
      .host_req   (host_req),
      .host_addr  (host_addr),
      .host_ack   (host_ack),
      .host_rdata (host_rdata),
      .sram_addr  (sram_addr),
      .sram_dout  (sram_dout),
      .sram_din   (sram_din),
      .sram_cs_n  (sram_cs_n),
      .sram_we_n  (sram_we_n),
      .sram_oe_n  (sram_oe_n),
      .ovf_clr    (ovf_clr),
      .wr_ptr     (wr_ptr),
      .wrapped    (wrapped),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   // Behavioural SRAM: asynchronous read, write on the clock edge while strobed.
   logic [DW-1:0] mem [1024];
   logic          pl_en = 1'b0;
   logic [AW-1:0] pl_addr = '0;
   logic [DW-1:0] pl_data = '0;

   always @(posedge clk) begin
      if (pl_en)
         mem[pl_addr] <= pl_data;
      else if (!sram_cs_n && !sram_we_n)
         mem[sram_addr] <= sram_dout;
   end
   assign sram_din = mem[sram_addr];

   // Monitor: grant order (0 = ADC, 1 = host), write log, ack count, strobe overlap.
   logic               grant_log [$];
   logic [AW+DW-1:0]   wr_log [$];
   int                 ack_cnt = 0;
   int                 viol = 0;
   logic               prev_we = 1'b1, prev_oe = 1'b1;

   always @(negedge clk) begin
      if (!sram_we_n && !sram_oe_n) viol = viol + 1;
      if (!sram_we_n && prev_we) grant_log.push_back(1'b0);
      if (!sram_oe_n && prev_oe) grant_log.push_back(1'b1);
      if (!sram_cs_n && !sram_we_n) wr_log.push_back({sram_addr, sram_dout});
      if (host_ack) ack_cnt = ack_cnt + 1;
      prev_we = sram_we_n;
      prev_oe = sram_oe_n;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n   = 1'b0;
      adc_valid = 1'b0;
      host_req  = 1'b0;
      ovf_clr   = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      tick();
   endtask

   task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
      pl_en   = 1'b1;
      pl_addr = a;
      pl_data = d;
      tick();
      pl_en = 1'b0;
   endtask

   task automatic wait_ready();
      int k = 0;
      while (!adc_ready && k < 8) begin
         tick();
         k++;
      end
      if (!adc_ready) check("ready_timeout", 32'(adc_ready), 1);
   endtask

   task automatic push_sample(input logic [DW-1:0] d);
      wait_ready();
      adc_valid = 1'b1;
      adc_data  = d;
      tick();
      adc_valid = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic exp_pat [4];
      int   g0;
      int   a0;
      exp_pat = '{1'b0, 1'b1, 1'b0, 1'b1};

      // Reset state
      do_reset();
      check("rst_strobes", {29'd0, sram_cs_n, sram_we_n, sram_oe_n}, 32'h7);
      check("rst_addr", 32'(sram_addr), 0);
      check("rst_dout", 32'(sram_dout), 0);
      check("rst_ack", 32'(host_ack), 0);
      check("rst_rdata", 32'(host_rdata), 0);
      check("rst_ptr_flags", {20'd0, wr_ptr, wrapped, overflow}, 0);
      check("rst_ready", 32'(adc_ready), 1);

      // Single sample 0xA5: accept T, IDLE T+1, WRITE T+2 at addr 0
      adc_valid = 1'b1;
      adc_data  = 8'hA5;
      tick();
      adc_valid = 1'b0;
      check("wr_t1_we_n", 32'(sram_we_n), 1);
      check("wr_t1_ready", 32'(adc_ready), 0);
      tick();
      check("wr_t2_strobes", {29'd0, sram_cs_n, sram_we_n, sram_oe_n}, 32'h1);
      check("wr_t2_addr", 32'(sram_addr), 0);
      check("wr_t2_dout", 32'(sram_dout), 32'hA5);
      check("wr_t2_ready", 32'(adc_ready), 1);
      tick();
      check("wr_t3_ptr", 32'(wr_ptr), 1);
      check("wr_t3_we_n", 32'(sram_we_n), 1);
      check("wr_mem0", 32'(mem[0]), 32'hA5);

      // Host read of 0x003 preloaded with 0x5C
      do_reset();
      preload(10'h003, 8'h5C);
      host_req  = 1'b1;
      host_addr = 10'h003;
      tick();
      check("rd_g1_strobes", {29'd0, sram_cs_n, sram_we_n, sram_oe_n}, 32'h2);
      check("rd_g1_addr", 32'(sram_addr), 3);
      check("rd_g1_ack", 32'(host_ack), 0);
      tick();
      check("rd_g2_strobes", {29'd0, sram_cs_n, sram_we_n, sram_oe_n}, 32'h2);
      check("rd_g2_ack", 32'(host_ack), 0);
      tick();
      check("rd_g3_ack", 32'(host_ack), 1);
      check("rd_g3_rdata", 32'(host_rdata), 32'h5C);
      check("rd_g3_strobes", {29'd0, sram_cs_n, sram_we_n, sram_oe_n}, 32'h7);
      tick();
      check("rd_ack_single", 32'(host_ack), 0);
      check("rd_req_ignored_on_ack", 32'(sram_oe_n), 1);
      host_req = 1'b0;

      // Contention: both pending, alternation and overflow
      do_reset();
      g0 = grant_log.size();
      adc_valid = 1'b1;
      adc_data  = 8'h11;
      tick();
      check("ovf_before_drop", 32'(overflow), 0);
      host_req  = 1'b1;
      host_addr = 10'h005;
      adc_data  = 8'h22;
      tick();
      check("ovf_first_drop", 32'(overflow), 1);
      for (int i = 0; i < 14; i++) begin
         adc_data = adc_data + 8'h11;
         tick();
      end
      adc_valid = 1'b0;
      host_req  = 1'b0;
      repeat (6) tick();
      check("rr_grant_count", 32'(grant_log.size() - g0 >= 4), 1);
      if (grant_log.size() - g0 >= 4)
         for (int i = 0; i < 4; i++)
            check($sformatf("rr_grant_%0d", i), 32'(grant_log[g0+i]), 32'(exp_pat[i]));
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      check("ovf_cleared", 32'(overflow), 0);

      // Drop coinciding with clear keeps overflow; held sample is untouched
      adc_valid = 1'b1;
      adc_data  = 8'h33;
      tick();
      check("hold_full_ready", 32'(adc_ready), 0);
      adc_data = 8'h44;
      ovf_clr  = 1'b1;
      tick();
      adc_valid = 1'b0;
      ovf_clr   = 1'b0;
      check("ovf_drop_beats_clr", 32'(overflow), 1);
      check("drop_keeps_hold", 32'(sram_dout), 32'h33);
      check("drop_write_strobe", 32'(sram_we_n), 0);

      // Wrap-around after 1024 samples
      do_reset();
      for (int i = 0; i < 1023; i++)
         push_sample(8'(i) ^ 8'h3C);
      repeat (3) tick();
      check("wrap_ptr_3ff", 32'(wr_ptr), 32'h3FF);
      check("wrap_not_yet", 32'(wrapped), 0);
      push_sample(8'hFF ^ 8'h3C);
      repeat (3) tick();
      check("wrap_ptr_0", 32'(wr_ptr), 0);
      check("wrap_flag", 32'(wrapped), 1);
      check("wrap_mem_3ff", 32'(mem[1023]), 32'hC3);
      push_sample(8'hEE);
      repeat (3) tick();
      check("wrap_1025_entry", wr_log[$], {10'h000, 8'hEE});
      check("wrap_1025_ptr", 32'(wr_ptr), 1);
      check("wrap_sticky", 32'(wrapped), 1);

      // Reset during READ aborts with no ack
      do_reset();
      host_req  = 1'b1;
      host_addr = 10'h003;
      tick();
      check("abort_rd_active", 32'(sram_oe_n), 0);
      a0 = ack_cnt;
      reset_n  = 1'b0;
      host_req = 1'b0;
      #1;
      check("abort_rd_strobes", {29'd0, sram_cs_n, sram_we_n, sram_oe_n}, 32'h7);
      check("abort_rd_ack", 32'(host_ack), 0);
      check("abort_rd_ptr", 32'(wr_ptr), 0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (4) tick();
      check("abort_rd_no_late_ack", 32'(ack_cnt - a0), 0);

      // Reset during WRITE aborts with no pointer increment
      adc_valid = 1'b1;
      adc_data  = 8'h77;
      tick();
      adc_valid = 1'b0;
      tick();
      check("abort_wr_active", 32'(sram_we_n), 0);
      reset_n = 1'b0;
      #1;
      check("abort_wr_we_n", 32'(sram_we_n), 1);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) tick();
      check("abort_wr_ptr", 32'(wr_ptr), 0);

      check("we_oe_overlap", 32'(viol), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/adc_sram_arbiter.md
ADC_SRAM_ARBITER -- requirements
Module: adc_sram_arbiter

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 8, sample/SRAM word width; ADDR_WIDTH, default 10, SRAM address width.
REQ-002 clk  input  1  single clock; all state SHALL be sampled on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 adc_valid  input  1  ADC sample offered.
REQ-005 adc_data  input  DATA_WIDTH  ADC sample.
REQ-006 adc_ready  output  1  sample accepted when adc_valid&&adc_ready.
REQ-007 host_req  input  1  level read request, held until host_ack.
REQ-008 host_addr  input  ADDR_WIDTH  read address, stable while host_req=1.
REQ-009 host_ack  output  1  one-cycle pulse; host_rdata valid in the same cycle.
REQ-010 host_rdata  output  DATA_WIDTH  registered read data.
REQ-011 sram_addr  output  ADDR_WIDTH  SRAM address.
REQ-012 sram_dout / sram_din  output / input  DATA_WIDTH  write data / read data.
REQ-013 sram_cs_n, sram_we_n, sram_oe_n  output  1 each  active-low SRAM strobes.
REQ-014 ovf_clr  input  1  clears overflow.
REQ-015 wr_ptr  output  ADDR_WIDTH  next write address; wrapped  output  1  sticky; overflow  output  1  sticky.

Function
REQ-016 A one-entry holding register SHALL buffer an accepted ADC sample; adc_ready = !hold_valid || (state==WRITE).
REQ-017 adc_valid while adc_ready=0 SHALL drop the sample and set overflow; holding contents SHALL be unchanged.
REQ-018 ovf_clr=1 SHALL clear overflow next cycle; simultaneous drop and ovf_clr SHALL leave overflow=1.
REQ-019 FSM states SHALL be IDLE, WRITE, READ, READ_CAP; WRITE and READ_CAP SHALL always return to IDLE.
REQ-020 In IDLE: hold_valid only -> WRITE; host_req only (and host_ack=0) -> READ; both -> round-robin, granting the requester not granted last; neither -> IDLE.
REQ-021 host_req SHALL be ignored in any cycle where host_ack=1.
REQ-022 SRAM strobes and address/data SHALL be registered and consistent with the state they belong to: WRITE: cs_n=0, we_n=0, oe_n=1, sram_addr=wr_ptr, sram_dout=held sample.
REQ-023 READ and READ_CAP: cs_n=0, oe_n=0, we_n=1, sram_addr=host_addr; sram_din SHALL be captured into host_rdata at the end of READ_CAP.
REQ-024 host_ack SHALL pulse for exactly the cycle following READ_CAP; read latency from grant = 3 cycles.
REQ-025 In IDLE all strobes SHALL be 1; we_n and oe_n SHALL never be 0 simultaneously.
REQ-026 At the end of WRITE, hold_valid SHALL clear (unless refilled in that cycle) and wr_ptr SHALL increment modulo 2^ADDR_WIDTH.
REQ-027 Increment from 2^ADDR_WIDTH-1 SHALL wrap wr_ptr to 0 and set wrapped; wrapped SHALL clear only on reset.
REQ-028 Sample accept to WRITE strobe SHALL be 2 cycles when uncontended (accept T, hold T+1/IDLE, WRITE T+2).

Reset
REQ-029 reset_n=0 SHALL immediately force: state IDLE, sram_cs_n/we_n/oe_n=1, sram_addr=0, sram_dout=0, host_ack=0, host_rdata=0, hold_valid=0, wr_ptr=0, wrapped=0, overflow=0, last-grant=host.
REQ-030 Reset mid-WRITE or mid-READ SHALL abort the access with no ack and no pointer increment.

Structure
REQ-031 Package adc_sram_pkg SHALL hold the state enum (2 bits) and grant encoding (GNT_ADC, GNT_HOST).
REQ-032 Round-robin decision SHALL be sub-module adc_sram_rr_arb (two requests, last-grant state, one-hot grant).

Verification
REQ-033 Single sample 0xA5 accepted at cycle T -> WRITE at T+2 with addr 0, we_n=cs_n=0, wr_ptr=1 after.
REQ-034 Host read addr 0x003 preloaded 0x5C, no ADC traffic -> host_ack 3 cycles after grant, host_rdata=0x5C, we_n=1 throughout.
REQ-035 host_req and hold_valid both pending from reset, sustained -> grants alternate ADC, host, ADC, host.
REQ-036 adc_valid held high every cycle with continuous host reads -> overflow=1 on first drop; ovf_clr pulse -> overflow=0.
REQ-037 1024 samples with ADDR_WIDTH=10 -> wr_ptr=0 and wrapped=1 after last WRITE; 1025th sample written at addr 0.
REQ-038 reset_n asserted during READ -> strobes 1 same cycle, no host_ack, wr_ptr=0.
